// File: rtl/pc_redirect_unit.sv
// IF-stage program counter: picks the next fetch address from sequential, branch,
// jump or exception sources, and buffers a redirect that arrives during a stall.
module pc_redirect_unit #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
   parameter int unsigned      INC          = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             exception,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus_inc,
   output logic             pc_valid,
   output logic             redirect,
   output logic             redir_pending,
   output logic             misaligned
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] pend_addr;
   logic             any_req;
   logic [WIDTH-1:0] req_target;

   assign pc_plus_inc   = pc + WIDTH'(INC);
   assign redir_pending = (state == PEND);
   assign misaligned    = pc_valid & (pc[1:0] != 2'b00);

   // Branch outranks jump when both are presented in the same cycle.
   assign any_req    = branch_taken | jump;
   assign req_target = branch_taken ? branch_target : jump_target;

   // stall is a hold request: while it is high the PC only moves for an exception;
   // a branch/jump seen during stall is captured once and applied when stall drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_VECTOR;
         pc_valid  <= 1'b0;
         redirect  <= 1'b0;
         pend_addr <= '0;
         state     <= BOOT;
      end else begin
         case (state)
            BOOT: begin
               pc_valid <= 1'b1;
               redirect <= 1'b0;
               state    <= RUN;
            end
            RUN: begin
               if (exception) begin
                  pc       <= EXC_VECTOR;
                  redirect <= 1'b1;
               end else if (!stall) begin
                  if (any_req) begin
                     pc       <= req_target;
                     redirect <= 1'b1;
                  end else begin
                     pc       <= pc_plus_inc;
                     redirect <= 1'b0;
                  end
               end else begin
                  redirect <= 1'b0;
                  if (any_req) begin
                     pend_addr <= req_target;
                     state     <= PEND;
                  end
               end
            end
            PEND: begin
               // The first captured redirect wins over anything presented later.
               if (exception) begin
                  pc       <= EXC_VECTOR;
                  redirect <= 1'b1;
                  state    <= RUN;
               end else if (!stall) begin
                  pc       <= pend_addr;
                  redirect <= 1'b1;
                  state    <= RUN;
               end else begin
                  redirect <= 1'b0;
               end
            end
            default: begin
               redirect <= 1'b0;
               state    <= RUN;
            end
         endcase
      end
   end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Parametrised program counter for the IF stage of the pipelined MIPS core.
- Holds the fetch PC and selects the next PC from one of four sources: sequential increment, taken branch, jump, or exception vector.
- Supports stall. A redirect that arrives while the pipe is stalled is buffered so it is not lost.
- Drives a one-cycle flush pulse to IF/ID when a redirect is applied.

Parameters:
- WIDTH, 32, PC width in bits (>= 8).
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h8000_0180, PC loaded on exception.
- INC, 4, sequential increment.

Ports:
- clk  in  1  Rising-edge clock; the only clock.
- reset  in  1  Synchronous reset, active-high.
- stall  in  1  Hazard unit requests PC hold.
- branch_taken  in  1  Branch resolved taken this cycle.
- branch_target  in  WIDTH  Branch destination.
- jump  in  1  Jump request this cycle.
- jump_target  in  WIDTH  Jump destination.
- exception  in  1  Exception request; overrides stall.
- pc  out  WIDTH  Current fetch address (registered).
- pc_plus_inc  out  WIDTH  pc + INC, combinational, modulo 2^WIDTH.
- pc_valid  out  1  pc is a real fetch address.
- redirect  out  1  Registered pulse: pc was just loaded from a non-sequential source; flush IF/ID.
- redir_pending  out  1  A buffered redirect is waiting for stall to drop.
- misaligned  out  1  pc_valid & (pc[1:0] != 0), combinational.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (synchronous, wins over everything):
  - pc = RESET_VECTOR; pc_valid = 0; redirect = 0; pend_addr = 0; state = BOOT.
  - redir_pending = 0.
  - A reset asserted mid-stall or mid-pending discards the buffered redirect.
- States: BOOT, RUN, PEND. redir_pending = (state == PEND).
- BOOT:
  - Lasts exactly one cycle after reset deasserts; inputs are ignored.
  - Next edge: pc_valid = 1, state = RUN, pc unchanged. First fetch is RESET_VECTOR.
- RUN, next-PC priority: exception > branch_taken > jump > sequential.
  - exception = 1: pc <= EXC_VECTOR, redirect <= 1. Applies regardless of stall.
  - stall = 0 with branch_taken or jump: pc <= selected target, redirect <= 1.
  - stall = 0 with no request: pc <= pc + INC, redirect <= 0.
  - stall = 1 with branch_taken or jump:
    - pend_addr <= higher-priority target (branch over jump).
    - state <= PEND; pc held; redirect <= 0.
  - stall = 1 with no request: pc held; redirect <= 0.
- PEND:
  - exception = 1: pc <= EXC_VECTOR, redirect <= 1, pending discarded, state <= RUN.
  - stall = 0: pc <= pend_addr, redirect <= 1, state <= RUN. Same-cycle branch_taken or jump is ignored; the buffered redirect wins.
  - stall = 1: hold pc and pend_addr. New branch_taken or jump is ignored; the first captured redirect wins.
- redirect is high for exactly one cycle per applied redirect. Back-to-back redirects produce back-to-back pulses.
- Arithmetic:
  - pc + INC wraps modulo 2^WIDTH; no overflow flag.
  - Targets are loaded verbatim, with no alignment masking.
  - misaligned flags an unaligned target; the unit does not trap on it.
- pc_valid stays 1 from the end of BOOT until the next reset.

Test Plan:
1. Reset and boot: assert reset for 2 cycles, then release → pc = 0 with pc_valid = 0 for one cycle; then pc = 0 with pc_valid = 1; then 4, 8, 12 on following cycles.
2. Stall hold with branch: pc = 0x10; stall for 3 cycles, then branch_taken with target 0x40 and stall = 0 → pc stays 0x10 during stall; pc = 0x40 on the branch edge; redirect high for one cycle; next pc = 0x44.
3. Buffered redirect:
   - Stimulus: pc = 0x20; stall = 1, then jump to 0x100 for one cycle; keep stall 2 more cycles while branch_taken to 0x200 is also presented.
   - Response: redir_pending = 1 and pc = 0x20 throughout the stall.
   - Response: on stall release, pc = 0x100 (the branch to 0x200 is ignored), redirect pulses once, and redir_pending = 0.
4. Exception priority:
   - In RUN, exception, branch_taken and stall all asserted together → pc = 0x80000180, redirect = 1.
   - In PEND, assert exception → pc = 0x80000180 and the pending redirect is discarded.
5. Wrap and misalignment:
   - Stimulus: WIDTH = 32; jump to 0xFFFFFFFC, then run sequentially → pc = 0x0 on the next cycle.
   - Stimulus: jump to 0x102 → misaligned = 1 while pc = 0x102.
6. Reset mid-PEND: enter PEND with target 0x300, then assert reset → pc = 0, redir_pending = 0, pc_valid = 0, and 0x300 is never loaded.
